// File: rtl/cavlc_pkg.sv
// Shared CAVLC definitions: level widths, encoder FSM states and the
// suffix-length escalation threshold used by both level encode and decode.
package cavlc_pkg;
    localparam int LEVEL_W      = 13;
    localparam int MAX_CODE_LEN = 28;
    localparam int LEVEL_MAX    = 2047;

    typedef enum logic [1:0] {IDLE, T1, LEVEL, DRAIN} encState_t;

    // Magnitude above which suffixLength grows: 3 << (sL-1), 0 for sL=0.
    function automatic logic [12:0] suffix_threshold(input logic [2:0] sL);
        if (sL == 3'd0) return 13'd0;
        return 13'd3 << (sL - 3'd1);
    endfunction
endpackage

// File: rtl/level_encode_if.sv
// Block-control, level-input and codeword-output signals of level_encode.
interface level_encode_if;
    import cavlc_pkg::*;

    logic                        Start;
    logic [4:0]                  TotalCoeff;
    logic [1:0]                  TrailingOnes;
    logic signed [LEVEL_W-1:0]   LevelIn;
    logic                        LevelValid;
    logic                        LevelReady;
    logic [MAX_CODE_LEN-1:0]     CodeWord;
    logic [4:0]                  CodeLen;
    logic                        CodeValid;
    logic                        CodeReady;
    logic                        Done;
    logic                        RangeErr;

    modport master (
        output Start, TotalCoeff, TrailingOnes, LevelIn, LevelValid, CodeReady,
        input  LevelReady, CodeWord, CodeLen, CodeValid, Done, RangeErr
    );

    modport slave (
        input  Start, TotalCoeff, TrailingOnes, LevelIn, LevelValid, CodeReady,
        output LevelReady, CodeWord, CodeLen, CodeValid, Done, RangeErr
    );
endinterface

// File: rtl/level_vlc_map.sv
// Combinational levelCode -> level_prefix/level_suffix codeword mapping.
// Codeword is right-aligned: prefix zeros, a one, then the suffix bits.
module level_vlc_map
    import cavlc_pkg::*;
(
    input  logic [12:0]             levelCode,
    input  logic [2:0]              suffixLen,
    output logic [MAX_CODE_LEN-1:0] codeWord,
    output logic [4:0]              codeLen
);
    logic [4:0]  prefix;
    logic [3:0]  sufBits;
    logic [11:0] suffix;
    logic [12:0] escBase;

    // Pick prefix/suffix split, then assemble word and length.
    always_comb begin
        prefix  = '0;
        sufBits = '0;
        suffix  = '0;
        escBase = 13'd15 << suffixLen;
        if (suffixLen == 3'd0) begin
            if (levelCode < 13'd14) begin
                prefix = levelCode[4:0];
            end else if (levelCode < 13'd30) begin
                prefix  = 5'd14;
                sufBits = 4'd4;
                suffix  = 12'(levelCode - 13'd14);
            end else begin
                prefix  = 5'd15;
                sufBits = 4'd12;
                suffix  = 12'(levelCode - 13'd30);
            end
        end else if (levelCode < escBase) begin
            prefix  = 5'(levelCode >> suffixLen);
            sufBits = {1'b0, suffixLen};
            suffix  = 12'(levelCode & ~(13'h1FFF << suffixLen));
        end else begin
            prefix  = 5'd15;
            sufBits = 4'd12;
            suffix  = 12'(levelCode - escBase);
        end
        codeWord = (MAX_CODE_LEN'(1) << sufBits) | MAX_CODE_LEN'(suffix);
        codeLen  = prefix + 5'd1 + {1'b0, sufBits};
    end
endmodule

// File: rtl/level_encode.sv
// CAVLC level encoder: per-block FSM, level counter, adaptive suffixLength,
// levelCode derivation with range clamping, and a single output register.
module level_encode
    import cavlc_pkg::*;
(
    input  logic           Clk,
    input  logic           nReset,
    level_encode_if.slave  bus
);
    encState_t   state, stateNext;
    logic [4:0]  cnt;
    logic [1:0]  t1Left;
    logic [2:0]  sL, sLStep, sLNext;
    logic        firstLvl;
    logic        accept, canLoad;
    logic        neg, outOfRange;
    logic [12:0] mag, minMag, cmag, baseCode, levelCode;
    logic [MAX_CODE_LEN-1:0] vlcWord;
    logic [4:0]  vlcLen;

    assign canLoad = !bus.CodeValid || bus.CodeReady;
    assign accept  = bus.LevelValid && bus.LevelReady;

    // Sign/magnitude, clamping, levelCode and the post-level suffixLength.
    always_comb begin
        neg        = bus.LevelIn[LEVEL_W-1];
        mag        = neg ? 13'(-bus.LevelIn) : 13'(bus.LevelIn);
        minMag     = firstLvl ? 13'd2 : 13'd1;
        outOfRange = (mag > 13'(LEVEL_MAX)) || (mag < minMag);
        if (mag > 13'(LEVEL_MAX)) cmag = 13'(LEVEL_MAX);
        else if (mag < minMag)    cmag = minMag;
        else                      cmag = mag;
        baseCode  = neg ? 13'({cmag, 1'b0} - 14'd1) : 13'({cmag, 1'b0} - 14'd2);
        levelCode = baseCode - (firstLvl ? 13'd2 : 13'd0);
        sLStep    = (sL == 3'd0) ? 3'd1 : sL;
        sLNext    = ((cmag > suffix_threshold(sLStep)) && (sLStep < 3'd6))
                    ? sLStep + 3'd1 : sLStep;
    end

    level_vlc_map uMap (
        .levelCode (levelCode),
        .suffixLen (sL),
        .codeWord  (vlcWord),
        .codeLen   (vlcLen)
    );

    // FSM state register.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) state <= IDLE;
        else         state <= stateNext;
    end

    // Next-state, level handshake and block-complete pulse.
    always_comb begin
        stateNext      = state;
        bus.LevelReady = 1'b0;
        bus.Done       = 1'b0;
        case (state)
            IDLE: if (bus.Start) begin
                if (bus.TotalCoeff == 5'd0)        stateNext = DRAIN;
                else if (bus.TrailingOnes != 2'd0) stateNext = T1;
                else                               stateNext = LEVEL;
            end
            T1: begin
                bus.LevelReady = canLoad;
                if (accept && t1Left == 2'd1)
                    stateNext = (cnt == 5'd1) ? DRAIN : LEVEL;
            end
            LEVEL: begin
                bus.LevelReady = canLoad;
                if (accept && cnt == 5'd1) stateNext = DRAIN;
            end
            DRAIN: if (!bus.CodeValid) begin
                bus.Done  = 1'b1;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // Block context: counters, suffixLength, first-level flag, sticky error.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            cnt          <= '0;
            t1Left       <= '0;
            sL           <= '0;
            firstLvl     <= 1'b0;
            bus.RangeErr <= 1'b0;
        end else if (state == IDLE && bus.Start) begin
            cnt          <= bus.TotalCoeff;
            t1Left       <= bus.TrailingOnes;
            sL           <= (bus.TotalCoeff > 5'd10 && bus.TrailingOnes != 2'd3) ? 3'd1 : 3'd0;
            firstLvl     <= (bus.TrailingOnes != 2'd3);
            bus.RangeErr <= 1'b0;
        end else if (accept) begin
            cnt <= cnt - 5'd1;
            if (state == T1) begin
                t1Left <= t1Left - 2'd1;
            end else begin
                sL       <= sLNext;
                firstLvl <= 1'b0;
                if (outOfRange) bus.RangeErr <= 1'b1;
            end
        end
    end

    // Output register: load on accept, drop valid when the packer takes it.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            bus.CodeValid <= 1'b0;
            bus.CodeWord  <= '0;
            bus.CodeLen   <= '0;
        end else if (accept) begin
            bus.CodeValid <= 1'b1;
            bus.CodeWord  <= (state == T1) ? MAX_CODE_LEN'(neg) : vlcWord;
            bus.CodeLen   <= (state == T1) ? 5'd1 : vlcLen;
        end else if (bus.CodeReady) begin
            bus.CodeValid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_level_encode.sv
// Scoreboard bench for level_encode: a driver pushes model codewords on each
// level acceptance; a monitor pops and compares on every codeword handshake.
module tb_level_encode;
    import cavlc_pkg::*;

    logic Clk = 1'b0;
    logic nReset = 1'b0;

    level_encode_if bus();

    level_encode dut (
        .Clk    (Clk),
        .nReset (nReset),
        .bus    (bus)
    );

    initial forever #5 Clk = ~Clk;

    typedef struct {
        logic [27:0] w;
        int          len;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   readyMode = 0;
    int   bpAt = -100;
    int   doneCnt = 0;
    int   hsCyc = 0;
    bit   blkHasCodes = 0;
    int   mSL;
    bit   mFirst;
    bit   mErr;
    int   lvBuf[16];

    task automatic check(input bit ok, input string name, input longint act, input longint req);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Reference encoder from the level_prefix/level_suffix rules.
    task automatic model_level(input int L, input bit isT1, output exp_t e);
        int mag, minm, lc, p, sn, s, esc;
        if (isT1) begin
            e.w = (L < 0) ? 28'd1 : 28'd0;
            e.len = 1;
            return;
        end
        mag  = (L < 0) ? -L : L;
        minm = mFirst ? 2 : 1;
        if (mag > 2047) begin mErr = 1; mag = 2047; end
        else if (mag < minm) begin mErr = 1; mag = minm; end
        lc = (L < 0) ? 2 * mag - 1 : 2 * mag - 2;
        if (mFirst) lc -= 2;
        mFirst = 0;
        if (mSL == 0) begin
            if (lc < 14)      begin p = lc; sn = 0;  s = 0;       end
            else if (lc < 30) begin p = 14; sn = 4;  s = lc - 14; end
            else              begin p = 15; sn = 12; s = lc - 30; end
        end else begin
            esc = 15 * (1 << mSL);
            if (lc < esc) begin p = lc / (1 << mSL); sn = mSL; s = lc % (1 << mSL); end
            else          begin p = 15; sn = 12; s = lc - esc; end
        end
        e.w   = 28'((1 << sn) + s);
        e.len = p + 1 + sn;
        if (mSL == 0) mSL = 1;
        if (mag > 3 * (1 << (mSL - 1)) && mSL < 6) mSL++;
    endtask

    function automatic int rand_level();
        int r, m;
        r = $urandom % 100;
        if (r < 4)       m = (($urandom % 2) == 0) ? 0 : 2048 + $urandom % 2000;
        else if (r < 60) m = 1 + $urandom % 6;
        else if (r < 90) m = 1 + $urandom % 40;
        else             m = 1 + $urandom % 2047;
        return (($urandom % 2) == 0) ? m : -m;
    endfunction

    // CodeReady source and cycle counter.
    initial begin
        bus.CodeReady = 1'b1;
        forever begin
            @(posedge Clk);
            #1;
            cyc++;
            if (cyc >= bpAt && cyc < bpAt + 5) bus.CodeReady = 1'b0;
            else if (readyMode == 0)           bus.CodeReady = 1'b1;
            else if (readyMode == 1)           bus.CodeReady = (($urandom % 4) != 0);
            else                               bus.CodeReady = 1'b0;
        end
    end

    // Monitor: codeword scoreboard, hold-stability, Done timing.
    initial begin
        logic [27:0] pw;
        logic [4:0]  pl;
        bit stall;
        exp_t e;
        stall = 0;
        forever begin
            @(negedge Clk);
            if (!nReset) begin
                stall = 0;
            end else begin
                if (stall)
                    check(bus.CodeValid && bus.CodeWord == pw && bus.CodeLen == pl, "hold_stable",
                          {bus.CodeValid, bus.CodeLen, bus.CodeWord}, {1'b1, pl, pw});
                if (bus.CodeValid && !bus.CodeReady)
                    check(!bus.LevelReady, "ready_low_stall", bus.LevelReady, 0);
                if (bus.CodeValid && bus.CodeReady) begin
                    check(sb.size() != 0, "unexpected_code", bus.CodeWord, 0);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        check(bus.CodeWord == e.w && bus.CodeLen == 5'(e.len), "codeword",
                              {bus.CodeLen, bus.CodeWord}, {5'(e.len), e.w});
                    end
                    hsCyc = cyc;
                end
                stall = bus.CodeValid && !bus.CodeReady;
                pw = bus.CodeWord;
                pl = bus.CodeLen;
                if (bus.Done) begin
                    doneCnt++;
                    check(sb.size() == 0, "done_sb_empty", sb.size(), 0);
                    if (blkHasCodes) check(cyc == hsCyc + 1, "done_latency", cyc - hsCyc, 1);
                end
            end
        end
    end

    task automatic run_block(input int tc, input int t1);
        int n;
        bit ok;
        exp_t e;
        mSL = (tc > 10 && t1 < 3) ? 1 : 0;
        mFirst = (t1 < 3);
        mErr = 0;
        blkHasCodes = (tc > 0);
        n = doneCnt;
        bus.Start = 1'b1;
        bus.TotalCoeff = 5'(tc);
        bus.TrailingOnes = 2'(t1);
        @(posedge Clk); #1;
        bus.Start = 1'b0;
        @(negedge Clk);
        check(bus.RangeErr == 1'b0, "start_clears_err", bus.RangeErr, 0);
        if (tc == 0) check(bus.Done == 1'b1, "tc0_done", bus.Done, 1);
        @(posedge Clk); #1;
        for (int i = 0; i < tc; i++) begin
            if (($urandom % 4) == 0) begin
                bus.LevelValid = 1'b0;
                @(posedge Clk); #1;
            end
            bus.LevelIn = 13'(lvBuf[i]);
            bus.LevelValid = 1'b1;
            ok = 0;
            for (int k = 0; k < 200 && !ok; k++) begin
                @(negedge Clk);
                if (bus.LevelReady) begin
                    model_level(lvBuf[i], i < t1, e);
                    sb.push_back(e);
                    ok = 1;
                end
                @(posedge Clk); #1;
            end
            check(ok, "level_accept", ok, 1);
        end
        bus.LevelValid = 1'b0;
        for (int k = 0; k < 200 && doneCnt == n; k++) @(negedge Clk);
        check(doneCnt == n + 1, "done_seen", doneCnt - n, 1);
        check(bus.RangeErr == mErr, "range_err", bus.RangeErr, mErr);
        @(posedge Clk); #1;
    endtask

    task automatic rand_block();
        int tc, t1, tmax;
        tc = $urandom % 17;
        tmax = (tc < 3) ? tc : 3;
        t1 = $urandom % (tmax + 1);
        for (int i = 0; i < tc; i++)
            lvBuf[i] = (i < t1) ? ((($urandom % 2) == 0) ? 1 : -1) : rand_level();
        run_block(tc, t1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.Start = 1'b0;
        bus.TotalCoeff = '0;
        bus.TrailingOnes = '0;
        bus.LevelIn = '0;
        bus.LevelValid = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        check(bus.CodeValid == 0 && bus.LevelReady == 0 && bus.Done == 0 && bus.RangeErr == 0,
              "reset_ctrl", {bus.CodeValid, bus.LevelReady, bus.Done, bus.RangeErr}, 0);
        check(bus.CodeWord == 0 && bus.CodeLen == 0, "reset_data", {bus.CodeLen, bus.CodeWord}, 0);
        nReset = 1'b1;
        @(posedge Clk); #1;

        // Trailing ones only.
        lvBuf[0] = 1; lvBuf[1] = -1; lvBuf[2] = 1;
        run_block(3, 3);
        // Suffix length escalation to 2.
        lvBuf[0] = 4; lvBuf[1] = 3;
        run_block(2, 0);
        // Single first levels covering each prefix/escape region.
        lvBuf[0] = 2;   run_block(1, 0);
        lvBuf[0] = -2;  run_block(1, 0);
        lvBuf[0] = 9;   run_block(1, 0);
        lvBuf[0] = 17;  run_block(1, 0);
        // Initial suffix length 1 for large blocks.
        lvBuf[0] = 2;
        for (int i = 1; i < 11; i++) lvBuf[i] = rand_level();
        run_block(11, 0);
        // Backpressure mid-block.
        for (int i = 0; i < 8; i++) lvBuf[i] = 1 + i * 3;
        bpAt = cyc + 5;
        run_block(8, 0);
        bpAt = -100;
        // Out-of-range level, then Start clears the flag.
        lvBuf[0] = 3000;
        run_block(1, 0);
        lvBuf[0] = 1; lvBuf[1] = -5;
        run_block(2, 1);
        // Empty block.
        run_block(0, 0);

        readyMode = 1;
        for (int b = 0; b < 40; b++) rand_block();
        readyMode = 0;

        // Reset in the middle of a stalled block.
        readyMode = 2;
        @(posedge Clk); #1;
        bus.Start = 1'b1; bus.TotalCoeff = 5'd5; bus.TrailingOnes = 2'd0;
        @(posedge Clk); #1;
        bus.Start = 1'b0; bus.LevelIn = 13'sd3000; bus.LevelValid = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        check(bus.CodeValid == 1'b1, "pre_reset_valid", bus.CodeValid, 1);
        #1;
        nReset = 1'b0;
        #1;
        check(bus.CodeValid == 0 && bus.LevelReady == 0 && bus.Done == 0 && bus.RangeErr == 0,
              "midreset_ctrl", {bus.CodeValid, bus.LevelReady, bus.Done, bus.RangeErr}, 0);
        check(bus.CodeWord == 0 && bus.CodeLen == 0, "midreset_data", {bus.CodeLen, bus.CodeWord}, 0);
        bus.LevelValid = 1'b0;
        sb.delete();
        @(negedge Clk);
        nReset = 1'b1;
        readyMode = 0;
        @(posedge Clk); #1;
        lvBuf[0] = -1; lvBuf[1] = 6; lvBuf[2] = -30;
        run_block(3, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/level_encode.md
# level_encode

Encoder-side counterpart of the CAVLC level decoder. Accepts one block's signed coefficient levels in CAVLC order, highest frequency first, with trailing ones leading. Produces one variable-length codeword per level, using the H.264 level_prefix/level_suffix code with adaptive suffix length. It sits between the coefficient-token encoder, which supplies TotalCoeff and TrailingOnes, and the bitstream packer, which consumes right-aligned codewords.

## Interface
- MAX_CODE_LEN, 28: longest codeword in bits (16 prefix + 12 suffix).
- Clk  in  1  clock, rising edge.
- nReset  in  1  asynchronous active-low reset.
- Start  in  1  one-cycle pulse in IDLE; latches TotalCoeff/TrailingOnes.
- TotalCoeff  in  5  number of levels in block (0..16).
- TrailingOnes  in  2  leading levels of magnitude 1 (0..3, ≤ TotalCoeff).
- LevelIn  in  13  signed level, two's complement.
- LevelValid  in  1  LevelIn valid.
- LevelReady  out  1  level accepted when LevelValid & LevelReady.
- CodeWord  out  28  codeword, right-aligned, MSB-first bit order within CodeLen.
- CodeLen  out  5  valid bits in CodeWord (1..28).
- CodeValid  out  1  codeword valid.
- CodeReady  in  1  packer accepts when CodeValid & CodeReady.
- Done  out  1  one-cycle pulse when block complete.
- RangeErr  out  1  sticky; set when an out-of-range level is seen; cleared by Start.

## Operation
- FSM states: IDLE, T1, LEVEL, DRAIN.
- IDLE → T1 on Start when TrailingOnes>0.
- IDLE → LEVEL on Start when TrailingOnes=0 and TotalCoeff>0.
- IDLE → DRAIN on Start when TotalCoeff=0.
- T1 → LEVEL after TrailingOnes accepts. T1 → DRAIN if TrailingOnes = TotalCoeff.
- LEVEL → DRAIN after the remaining levels are accepted.
- DRAIN → IDLE once the output register is empty. Done pulses on that transition.
- A down-counter loaded with TotalCoeff decrements on each accepted level.
- Start outside IDLE is ignored.
- T1 encoding: CodeLen=1, CodeWord[0]=LevelIn sign (1 = negative). Magnitude is not checked.
- Non-T1 levelCode: 2·L−2 for L>0, −2·L−1 for L<0.
  - The first non-T1 level with TrailingOnes<3 gets levelCode −2. Its |L| must be ≥2.
  - |L|>2047, L=0, or a violating first level sets RangeErr. The level is then clamped to ±2047, or to ±2 where that rule applies.
- SuffixLength (sL, 3 bits) init: 1 if TotalCoeff>10 and TrailingOnes<3, else 0.
- Code for sL=0:
  - levelCode<14: prefix=levelCode, no suffix.
  - levelCode<30: prefix 14, 4-bit suffix levelCode−14.
  - otherwise: prefix 15, 12-bit suffix levelCode−30.
- Code for sL>0:
  - levelCode < (15<<sL): prefix=levelCode>>sL, sL-bit suffix = low sL bits of levelCode.
  - otherwise: prefix 15, 12-bit suffix levelCode−(15<<sL).
- Codeword layout: prefix zeros, a one, then the suffix. CodeLen = prefix+1+suffix size.
- sL update after each non-T1 level:
  - If sL=0, sL←1.
  - Then, if |L| > (3<<(sL−1)) and sL<6, sL←sL+1.
  - Both steps happen in the same cycle as the acceptance.
- No sL update on T1s.

## Timing
- Reset values: LevelReady=0, CodeValid=0, CodeWord=0, CodeLen=0, Done=0, RangeErr=0. FSM=IDLE, sL=0, counter=0.
- Single output register. Codeword is valid the cycle after the level is accepted.
- LevelReady = (state∈{T1,LEVEL}) & (!CodeValid | CodeReady). This gives full throughput of one level per cycle.
- CodeWord/CodeLen hold stable while CodeValid & !CodeReady.
- Done asserts the cycle after the last codeword handshake.
- TotalCoeff=0: Done asserts 1 cycle after Start. No CodeValid.
- nReset mid-block: immediate return to reset values. The pending codeword is discarded.

## Structure
- Shared cavlc_pkg holds:
  - constants LEVEL_W=13, MAX_CODE_LEN=28, LEVEL_MAX=2047;
  - the state enum;
  - function suffix_threshold(sL), shared with LevelDecode's threshold rule.
- Sub-module level_vlc_map (combinational) maps (levelCode, sL) → (CodeWord, CodeLen).
- level_encode holds the FSM, counter, sL register, levelCode computation and output register.

## Test plan
- TotalCoeff=3, TrailingOnes=3, levels +1,−1,+1 → codes (0,len1), (1,len1), (0,len1); Done 1 cycle after third handshake.
- TotalCoeff=2, TrailingOnes=0:
  - +4 → CodeWord=0x1, CodeLen=5; sL becomes 2.
  - +3 → CodeWord=0x4, CodeLen=4.
- TotalCoeff=1, TrailingOnes=0, level:
  - +2 → (0x1,1)
  - −2 → (0x1,2)
  - +9 → (0x10,19)
  - +17 → (0x1000,28)
- TotalCoeff=11, TrailingOnes=0, first level +2 → initial sL=1, code (0x2,2). Then sL stays 1.
- Backpressure: CodeReady=0 for 5 cycles mid-block → LevelReady=0, CodeWord stable; after release, no codes are lost or duplicated.
- Level +3000 → RangeErr=1, encoded as 2047. Start clears RangeErr. TotalCoeff=0 → Done only. nReset mid-block → all outputs at reset values next edge.
